// File: rtl/led_chaser_seq.sv
// led_chaser_seq -- one-hot 4-LED chaser driven by debounced button pulses.
//
// Mode A bounces 0-1-2-3-2-1-0; mode B rotates 0-1-2-3-0. Each position is
// held for CLK_HZ*FAST_S or CLK_HZ*SLOW_S clock cycles, depending on speed.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   mode_pulse  1-cycle pulse: toggle mode A/B, restart pattern at LED0
//   speed_pulse 1-cycle pulse: toggle fast/slow, restart the step timer
//   pause_pulse 1-cycle pulse: toggle run/paused (timer holds while paused)
//   leds        registered one-hot LED drive
//   step_tick   registered, high one cycle per position advance
//   mode_b      registered, 0 = mode A (bounce), 1 = mode B (rotate)
//   speed_slow  registered, 0 = fast, 1 = slow
//   paused      registered, 1 = advancing frozen
module led_chaser_seq #(
  parameter int CLK_HZ = 125000000,
  parameter int FAST_S = 1,
  parameter int SLOW_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_pulse,
  input  logic       speed_pulse,
  input  logic       pause_pulse,
  output logic [3:0] leds,
  output logic       step_tick,
  output logic       mode_b,
  output logic       speed_slow,
  output logic       paused
);

  localparam int SLOW_CYC = CLK_HZ * SLOW_S;
  localparam int FAST_CYC = CLK_HZ * FAST_S;
  // Guard against a zero-width counter for degenerate tiny periods.
  localparam int CW = (SLOW_CYC > 1) ? $clog2(SLOW_CYC) : 1;
  localparam logic [CW-1:0] TC_FAST = CW'(FAST_CYC - 1);
  localparam logic [CW-1:0] TC_SLOW = CW'(SLOW_CYC - 1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [CW-1:0] cnt;
  logic [1:0]    pos;
  dir_t          dir;

  logic [CW-1:0] tc;
  logic          at_tc;
  logic [1:0]    nxt_pos;
  dir_t          nxt_dir;

  assign tc    = speed_slow ? TC_SLOW : TC_FAST;
  assign at_tc = (cnt == tc);

  // Next position/direction for an advance in the current mode.
  always_comb begin
    nxt_pos = pos + 2'd1;
    nxt_dir = DIR_UP;
    if (!mode_b) begin
      if (dir == DIR_UP) begin
        nxt_pos = pos + 2'd1;
        nxt_dir = (nxt_pos == 2'd3) ? DIR_DOWN : DIR_UP;
      end else begin
        nxt_pos = pos - 2'd1;
        nxt_dir = (nxt_pos == 2'd0) ? DIR_UP : DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      pos        <= 2'd0;
      dir        <= DIR_UP;
      leds       <= 4'b0001;
      step_tick  <= 1'b0;
      mode_b     <= 1'b0;
      speed_slow <= 1'b0;
      paused     <= 1'b0;
    end else begin
      step_tick <= 1'b0;

      if (pause_pulse) paused <= ~paused;

      if (mode_pulse || speed_pulse) begin
        // A restart wins over a terminal-count step in the same cycle.
        cnt <= '0;
        if (mode_pulse) begin
          mode_b <= ~mode_b;
          pos    <= 2'd0;
          dir    <= DIR_UP;
          leds   <= 4'b0001;
        end
        if (speed_pulse) speed_slow <= ~speed_slow;
      end else if (!paused) begin
        // Uses the pre-toggle paused value, so a pause pulse landing on
        // the terminal count still lets this step through.
        if (at_tc) begin
          cnt       <= '0;
          pos       <= nxt_pos;
          dir       <= nxt_dir;
          leds      <= 4'b0001 << nxt_pos;
          step_tick <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_chaser_seq.sv
// Directed bench for led_chaser_seq with CLK_HZ=8, FAST_S=1, SLOW_S=3
// (fast step = 8 cycles, slow step = 24 cycles).
module tb_led_chaser_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_pulse = 1'b0;
  logic       speed_pulse = 1'b0;
  logic       pause_pulse = 1'b0;
  logic [3:0] leds;
  logic       step_tick;
  logic       mode_b;
  logic       speed_slow;
  logic       paused;

  int checks = 0;
  int errors = 0;

  led_chaser_seq #(.CLK_HZ(8), .FAST_S(1), .SLOW_S(3)) dut (
    .clk(clk), .rst(rst),
    .mode_pulse(mode_pulse), .speed_pulse(speed_pulse), .pause_pulse(pause_pulse),
    .leds(leds), .step_tick(step_tick), .mode_b(mode_b),
    .speed_slow(speed_slow), .paused(paused)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset held across one edge, released 1ns after it; counter then starts at 0.
  task automatic do_reset();
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    edges(2);
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL reset_leds got %b exp 0001", leds); end
    checks++; if ({step_tick, mode_b, speed_slow, paused} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {step_tick, mode_b, speed_slow, paused}); end
    rst = 1'b0;
  endtask

  task automatic test_mode_a();
    logic [3:0] seq [7];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset();
    for (int k = 1; k < 7; k++) begin
      edges(7);
      checks++; if (leds !== seq[k-1] || step_tick !== 1'b0) begin
        errors++; $display("FAIL modeA_hold%0d got %b/%b exp %b/0", k, leds, step_tick, seq[k-1]); end
      edges(1);
      checks++; if (leds !== seq[k] || step_tick !== 1'b1) begin
        errors++; $display("FAIL modeA_step%0d got %b/%b exp %b/1", k, leds, step_tick, seq[k]); end
    end
  endtask

  task automatic test_mode_change();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    edges(32);  // four steps: at 0100 heading down, cnt=0
    edges(2);
    checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL mc_pre got %b exp 0100", leds); end
    mode_pulse = 1'b1; edges(1); mode_pulse = 1'b0;
    checks++; if (leds !== 4'b0001 || mode_b !== 1'b1 || step_tick !== 1'b0) begin
      errors++; $display("FAIL mc_after got %b/%b/%b exp 0001/1/0", leds, mode_b, step_tick); end
    for (int k = 1; k < 5; k++) begin
      edges(7);
      checks++; if (leds !== seq[k-1]) begin errors++; $display("FAIL mc_hold%0d got %b exp %b", k, leds, seq[k-1]); end
      edges(1);
      checks++; if (leds !== seq[k] || step_tick !== 1'b1) begin
        errors++; $display("FAIL mc_step%0d got %b/%b exp %b/1", k, leds, step_tick, seq[k]); end
    end
  endtask

  task automatic test_speed();
    do_reset();
    mode_pulse = 1'b1; edges(1); mode_pulse = 1'b0;  // mode B, cnt=0
    edges(8);
    edges(5);  // at 0010, cnt=5
    checks++; if (leds !== 4'b0010) begin errors++; $display("FAIL sp_pre got %b exp 0010", leds); end
    speed_pulse = 1'b1; edges(1); speed_pulse = 1'b0;
    checks++; if (speed_slow !== 1'b1 || leds !== 4'b0010 || mode_b !== 1'b1) begin
      errors++; $display("FAIL sp_after got %b/%b/%b exp 1/0010/1", speed_slow, leds, mode_b); end
    edges(23);
    checks++; if (leds !== 4'b0010 || step_tick !== 1'b0) begin
      errors++; $display("FAIL sp_hold got %b/%b exp 0010/0", leds, step_tick); end
    edges(1);
    checks++; if (leds !== 4'b0100 || step_tick !== 1'b1) begin
      errors++; $display("FAIL sp_step1 got %b/%b exp 0100/1", leds, step_tick); end
    edges(23);
    checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL sp_hold2 got %b exp 0100", leds); end
    edges(1);
    checks++; if (leds !== 4'b1000 || step_tick !== 1'b1) begin
      errors++; $display("FAIL sp_step2 got %b/%b exp 1000/1", leds, step_tick); end
  endtask

  task automatic test_pause();
    int bad;
    do_reset();
    edges(3);  // cnt=3
    pause_pulse = 1'b1; edges(1); pause_pulse = 1'b0;
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_set got %b exp 1", paused); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      edges(1);
      if (leds !== 4'b0001 || step_tick !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_frozen got %0d bad cycles exp 0", bad); end
    pause_pulse = 1'b1; edges(1); pause_pulse = 1'b0;
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_clr got %b exp 0", paused); end
    edges(3);
    checks++; if (leds !== 4'b0001 || step_tick !== 1'b0) begin
      errors++; $display("FAIL resume_hold got %b/%b exp 0001/0", leds, step_tick); end
    edges(1);  // fifth edge after the resume pulse
    checks++; if (leds !== 4'b0010 || step_tick !== 1'b1) begin
      errors++; $display("FAIL resume_step got %b/%b exp 0010/1", leds, step_tick); end
    // Pause arriving on the terminal count: step still happens.
    edges(7);
    pause_pulse = 1'b1; edges(1); pause_pulse = 1'b0;
    checks++; if (leds !== 4'b0100 || step_tick !== 1'b1 || paused !== 1'b1) begin
      errors++; $display("FAIL pause_tc got %b/%b/%b exp 0100/1/1", leds, step_tick, paused); end
    edges(10);
    checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL pause_tc_hold got %b exp 0100", leds); end
    // Mode change while paused keeps paused.
    mode_pulse = 1'b1; edges(1); mode_pulse = 1'b0;
    checks++; if (leds !== 4'b0001 || mode_b !== 1'b1 || paused !== 1'b1) begin
      errors++; $display("FAIL pause_mode got %b/%b/%b exp 0001/1/1", leds, mode_b, paused); end
  endtask

  task automatic test_collision();
    do_reset();
    edges(7);  // cnt=7 = fast TC
    mode_pulse = 1'b1; speed_pulse = 1'b1; edges(1); mode_pulse = 1'b0; speed_pulse = 1'b0;
    checks++; if (step_tick !== 1'b0 || leds !== 4'b0001 || mode_b !== 1'b1 || speed_slow !== 1'b1) begin
      errors++; $display("FAIL coll got tick=%b leds=%b mb=%b sl=%b exp 0/0001/1/1", step_tick, leds, mode_b, speed_slow); end
    edges(23);
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL coll_hold got %b exp 0001", leds); end
    edges(1);
    checks++; if (leds !== 4'b0010 || step_tick !== 1'b1) begin
      errors++; $display("FAIL coll_step got %b/%b exp 0010/1", leds, step_tick); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode_pulse = 1'b1; speed_pulse = 1'b1; edges(1); mode_pulse = 1'b0; speed_pulse = 1'b0;
    edges(72);  // three slow steps in mode B
    checks++; if (leds !== 4'b1000 || mode_b !== 1'b1 || speed_slow !== 1'b1) begin
      errors++; $display("FAIL ar_pre got %b/%b/%b exp 1000/1/1", leds, mode_b, speed_slow); end
    #2 rst = 1'b1;
    #1;
    checks++; if (leds !== 4'b0001 || {mode_b, speed_slow, paused, step_tick} !== 4'b0000) begin
      errors++; $display("FAIL ar_async got %b/%b exp 0001/0000", leds, {mode_b, speed_slow, paused, step_tick}); end
    edges(1);
    rst = 1'b0;
    edges(8);
    checks++; if (leds !== 4'b0010 || step_tick !== 1'b1 || mode_b !== 1'b0) begin
      errors++; $display("FAIL ar_restart got %b/%b/%b exp 0010/1/0", leds, step_tick, mode_b); end
  endtask

  initial begin
    test_reset();
    test_mode_a();
    test_mode_change();
    test_speed();
    test_pause();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
